// File: rtl/port_pkg.sv
// Shared types and constants for the input-port datapath.
// Used by the port FIFO and the input-port FSM.
package port_pkg;

  localparam int W_WIDTH = 8;

  typedef struct packed {
    logic               eof;
    logic [W_WIDTH-1:0] data;
  } entry_t;

  localparam logic [7:0] SOF_BYTE = 8'hFF;

endpackage

// File: rtl/fifo_mem.sv
// Register-array FIFO storage: one synchronous write port, one registered read port.
// The head entry's MSB is also exposed combinationally so callers can act on it in the pop cycle.
module fifo_mem #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic                     head_msb_o,
  output logic [WIDTH-1:0]         rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage carries no reset; only entries that were written are ever read.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign head_msb_o = mem_q[rd_addr_i][WIDTH-1];
  assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/port_in_fifo.sv
// Per-port input buffer: delays the byte stream one stage to tag end-of-frame,
// stores tagged bytes in a circular FIFO, counts whole frames and drives port_busy upstream.
module port_in_fifo #(
  parameter  int W_WIDTH   = port_pkg::W_WIDTH,
  parameter  int DEPTH     = 8,
  parameter  int AF_MARGIN = 2,
  localparam int PW        = $clog2(DEPTH),
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [W_WIDTH-1:0] data_in,
  input  logic               rd_en,
  input  logic               clr_err,
  output logic [W_WIDTH-1:0] data_out,
  output logic               eof_out,
  output logic               rd_vld,
  output logic               empty,
  output logic               full,
  output logic               port_busy,
  output logic [LW-1:0]      level,
  output logic [LW-1:0]      frame_cnt,
  output logic               ovf,
  output logic               udf
);

  logic [W_WIDTH-1:0] stage_q, stage_d;
  logic               stage_vld_q, stage_vld_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic [LW-1:0]      frame_q, frame_d;
  logic               rd_vld_q;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;

  logic               is_empty, is_full;
  logic               push_req, push_eof, push_ok, pop_ok, head_eof;
  logic [W_WIDTH:0]   push_entry, rd_entry;

  assign is_empty = (level_q == '0);
  assign is_full  = (level_q == LW'(DEPTH));

  always_comb begin
    // A staged byte is the frame's last one exactly when no new byte follows it.
    push_req    = stage_vld_q;
    push_eof    = !wr_en;
    push_entry  = {push_eof, stage_q};
    pop_ok      = rd_en && !is_empty;
    push_ok     = push_req && (!is_full || pop_ok);

    stage_d     = wr_en ? data_in : stage_q;
    stage_vld_d = wr_en;

    wr_ptr_d    = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop_ok  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d     = level_q + LW'(push_ok) - LW'(pop_ok);
    frame_d     = frame_q + LW'(push_ok && push_eof) - LW'(pop_ok && head_eof);

    ovf_d       = (push_req && !push_ok) ? 1'b1 : (ovf_q && !clr_err);
    udf_d       = (rd_en && is_empty)    ? 1'b1 : (udf_q && !clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      frame_q     <= '0;
      rd_vld_q    <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      stage_q     <= stage_d;
      stage_vld_q <= stage_vld_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      frame_q     <= frame_d;
      rd_vld_q    <= pop_ok;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
    end
  end

  fifo_mem #(
    .WIDTH (W_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (push_ok),
    .wr_addr_i  (wr_ptr_q),
    .wr_data_i  (push_entry),
    .rd_en_i    (pop_ok),
    .rd_addr_i  (rd_ptr_q),
    .head_msb_o (head_eof),
    .rd_data_o  (rd_entry)
  );

  assign data_out  = rd_entry[W_WIDTH-1:0];
  assign eof_out   = rd_entry[W_WIDTH];
  assign rd_vld    = rd_vld_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign port_busy = (level_q >= LW'(DEPTH - AF_MARGIN));
  assign level     = level_q;
  assign frame_cnt = frame_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;

  a_level_max : assert property (@(posedge clk) disable iff (!rst_n) level_q <= LW'(DEPTH));
  a_frame_le  : assert property (@(posedge clk) disable iff (!rst_n) frame_q <= level_q);

endmodule

// File: tb/tb_port_in_fifo.sv
// Bench for port_in_fifo: directed frames plus random traffic, checked every cycle
// against a queue-based model of the tagged byte stream.
module tb_port_in_fifo;
  import port_pkg::*;

  localparam int DEPTH     = 8;
  localparam int AF_MARGIN = 2;
  localparam int LW        = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               wr_en = 1'b0;
  logic [W_WIDTH-1:0] data_in = '0;
  logic               rd_en = 1'b0;
  logic               clr_err = 1'b0;
  logic [W_WIDTH-1:0] data_out;
  logic               eof_out, rd_vld, empty, full, port_busy, ovf, udf;
  logic [LW-1:0]      level, frame_cnt;

  int vectors = 0;
  int miscompares = 0;

  entry_t             mq[$];
  logic [W_WIDTH-1:0] m_stage = '0;
  bit                 m_svld = 0;
  logic [W_WIDTH-1:0] m_dout = '0;
  bit                 m_eof = 0, m_vld = 0, m_ovf = 0, m_udf = 0;

  port_in_fifo #(.W_WIDTH(W_WIDTH), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .clr_err(clr_err), .data_out(data_out), .eof_out(eof_out), .rd_vld(rd_vld),
    .empty(empty), .full(full), .port_busy(port_busy), .level(level),
    .frame_cnt(frame_cnt), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_frames();
    int n = 0;
    foreach (mq[i]) if (mq[i].eof) n++;
    return n;
  endfunction

  // Model step and full output compare, one per clock edge out of reset.
  always @(posedge clk) begin : cmp_p
    bit we, re, ce, rn, pop_now, ovf_set, udf_set;
    logic [W_WIDTH-1:0] din;
    entry_t e;
    we = wr_en; re = rd_en; ce = clr_err; rn = rst_n; din = data_in;
    #1;
    if (!rn || !rst_n) begin
      mq.delete();
      m_stage = '0; m_svld = 0; m_dout = '0; m_eof = 0; m_vld = 0; m_ovf = 0; m_udf = 0;
    end else begin
      pop_now = re && (mq.size() > 0);
      udf_set = re && (mq.size() == 0);
      ovf_set = 0;
      m_vld   = pop_now;
      if (pop_now) begin
        e = mq.pop_front();
        m_dout = e.data;
        m_eof  = e.eof;
      end
      if (m_svld) begin
        if (mq.size() < DEPTH) begin
          e.eof = !we; e.data = m_stage;
          mq.push_back(e);
        end else ovf_set = 1;
      end
      if (we) begin m_stage = din; m_svld = 1; end
      else m_svld = 0;
      m_ovf = ovf_set || (m_ovf && !ce);
      m_udf = udf_set || (m_udf && !ce);

      chk("level",     32'(level),     32'(mq.size()));
      chk("frame_cnt", 32'(frame_cnt), 32'(m_frames()));
      chk("empty",     32'(empty),     32'(mq.size() == 0));
      chk("full",      32'(full),      32'(mq.size() == DEPTH));
      chk("port_busy", 32'(port_busy), 32'(mq.size() >= DEPTH - AF_MARGIN));
      chk("rd_vld",    32'(rd_vld),    32'(m_vld));
      chk("data_out",  32'(data_out),  32'(m_dout));
      chk("eof_out",   32'(eof_out),   32'(m_eof));
      chk("ovf",       32'(ovf),       32'(m_ovf));
      chk("udf",       32'(udf),       32'(m_udf));
    end
  end

  task automatic drive(input bit we, input logic [W_WIDTH-1:0] d, input bit re, input bit ce = 0);
    wr_en = we; data_in = d; rd_en = re; clr_err = ce;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_level"}, 32'(level), 0);
    chk({tag, "_frame"}, 32'(frame_cnt), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"},  32'(full), 0);
    chk({tag, "_busy"},  32'(port_busy), 0);
    chk({tag, "_rdvld"}, 32'(rd_vld), 0);
    chk({tag, "_dout"},  32'(data_out), 0);
    chk({tag, "_eof"},   32'(eof_out), 0);
    chk({tag, "_ovf"},   32'(ovf), 0);
    chk({tag, "_udf"},   32'(udf), 0);
  endtask

  initial begin
    logic [W_WIDTH-1:0] fr [4];
    fr[0] = 8'hA1; fr[1] = 8'hA2; fr[2] = 8'hA3; fr[3] = 8'hA4;

    #12;
    chk_reset_vals("rst0");
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0);

    // Four-byte frame, then idle so the EOF byte lands.
    for (int i = 0; i < 4; i++) drive(1, fr[i], 0);
    drive(0, 0, 0);
    chk("f4_level", 32'(level), 4);
    chk("f4_frame", 32'(frame_cnt), 1);

    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1);
      chk("pop_vld",  32'(rd_vld), 1);
      chk("pop_data", 32'(data_out), 32'(fr[i]));
      chk("pop_eof",  32'(eof_out), 32'(i == 3));
    end
    drive(0, 0, 0);
    chk("drain_frame", 32'(frame_cnt), 0);
    chk("drain_empty", 32'(empty), 1);
    chk("drain_vld",   32'(rd_vld), 0);
    chk("hold_data",   32'(data_out), 32'(8'hA4));

    // Ten bytes with no reads: almost-full, full, then overflow.
    for (int i = 1; i <= 10; i++) begin
      drive(1, 8'(i), 0);
      if (i == 6) chk("af_busy_lo", 32'(port_busy), 0);
      if (i == 7) begin chk("af_level", 32'(level), 6); chk("af_busy", 32'(port_busy), 1); end
      if (i == 9) begin chk("full_flag", 32'(full), 1); chk("full_noovf", 32'(ovf), 0); end
      if (i == 10) chk("ovf_set", 32'(ovf), 1);
    end
    drive(0, 0, 0);
    chk("ovf_level", 32'(level), 8);
    chk("ovf_frame", 32'(frame_cnt), 0);
    drive(0, 0, 0, 1);
    chk("ovf_clr", 32'(ovf), 0);

    // Full FIFO, push and pop together; order must survive pointer wrap.
    drive(1, 8'h50, 0);
    for (int k = 1; k <= 5; k++) begin
      drive(1, 8'(8'h50 + k), 1);
      chk("pp_level", 32'(level), 8);
      chk("pp_data",  32'(data_out), 32'(k));
    end
    drive(0, 0, 1);
    chk("pp_ovf",   32'(ovf), 0);
    chk("pp_frame", 32'(frame_cnt), 1);
    for (int k = 0; k < 9; k++) begin
      drive(0, 0, 1);
      if (k == 0) chk("pp_wrap0", 32'(data_out), 7);
      if (k == 2) chk("pp_wrap2", 32'(data_out), 32'(8'h50));
      if (k == 7) chk("pp_last_eof", 32'(eof_out), 1);
    end
    drive(0, 0, 0, 1);

    // Single-byte frame while reading an empty FIFO.
    drive(1, 8'h3C, 1);
    chk("sb_udf", 32'(udf), 1);
    chk("sb_vld", 32'(rd_vld), 0);
    drive(0, 0, 1);
    chk("sb_level", 32'(level), 1);
    chk("sb_frame", 32'(frame_cnt), 1);
    chk("sb_vld2",  32'(rd_vld), 0);
    drive(0, 0, 1, 1);
    chk("sb_data", 32'(data_out), 32'(8'h3C));
    chk("sb_eof",  32'(eof_out), 1);
    chk("sb_clr",  32'(udf), 0);

    // Random traffic: a fill-biased phase then a drain-biased phase.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), (n < 200) ? ($urandom_range(0, 3) == 0)
                                                                 : ($urandom_range(0, 3) != 0),
            $urandom_range(0, 15) == 0);
    end
    for (int n = 0; n < DEPTH + 2; n++) drive(0, 0, 1);
    drive(0, 0, 0, 1);

    // Reset in the middle of a frame.
    for (int i = 0; i < 4; i++) drive(1, 8'(8'hC0 + i), 0);
    chk("mid_level", 32'(level), 3);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    wr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) drive(0, 0, 0);
    chk("post_level", 32'(level), 0);
    chk("post_frame", 32'(frame_cnt), 0);
    chk("post_empty", 32'(empty), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/port_in_fifo.md
Name: port_in_fifo

Overview:
- Per-port buffer directly downstream of the input-port FSM.
- Consumes that FSM's registered wr_en and the raw data_in byte stream, and tags the last byte of each frame with an EOF bit.
- Stores tagged bytes in a circular FIFO, presents them to the output/arbitration stage, and counts complete frames.
- Drives port_busy back upstream so the input FSM refuses or aborts frames when space runs low.

Parameters:
W_WIDTH, 8, data byte width.
DEPTH, 8, FIFO entries; power of 2, >= 4.
AF_MARGIN, 2, port_busy asserts when free entries <= AF_MARGIN.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
wr_en  in  1  write enable from the input FSM; high for every payload byte.
data_in  in  W_WIDTH  byte, sampled when wr_en=1.
rd_en  in  1  pop request from the downstream stage.
clr_err  in  1  synchronous clear of the sticky error flags.
data_out  out  W_WIDTH  popped byte, registered.
eof_out  out  1  popped byte is the last byte of its frame.
rd_vld  out  1  data_out/eof_out valid this cycle (one-cycle pulse).
empty  out  1  level==0.
full  out  1  level==DEPTH.
port_busy  out  1  level >= DEPTH-AF_MARGIN.
level  out  $clog2(DEPTH)+1  stored entries; excludes the stage register.
frame_cnt  out  $clog2(DEPTH)+1  complete frames (EOF entries) held.
ovf  out  1  sticky: a push was dropped because the FIFO was full.
udf  out  1  sticky: rd_en was asserted while empty.

Behaviour:
- Reset (async, rst_n=0):
  - ptrs, level, frame_cnt, stage_vld, data_out, eof_out, rd_vld, ovf, udf = 0.
  - empty=1, full=0, port_busy=0.
- Stage register (end-of-frame detection):
  - wr_en=1: stage <= data_in, stage_vld <= 1.
  - stage_vld=1 and wr_en=1: push {eof=0, stage}.
  - stage_vld=1 and wr_en=0: push {eof=1, stage}, stage_vld <= 0.
  - A byte reaches memory one cycle after capture. The EOF byte lands 1 cycle after wr_en falls.
  - A single-byte frame (one wr_en pulse) produces one entry with eof=1.
- Push:
  - If full and no pop in the same cycle: entry dropped, ovf <= 1, frame_cnt unchanged.
  - Otherwise: write at wr_ptr, wr_ptr++ with modulo-DEPTH wrap.
  - frame_cnt++ when the pushed entry has eof=1.
- Pop:
  - rd_en=1 and !empty: entry at rd_ptr goes to data_out/eof_out the next cycle, rd_vld=1 that cycle; rd_ptr++ with wrap.
  - frame_cnt-- when the popped entry has eof=1.
  - rd_en=1 and empty: no pop, rd_vld stays 0, udf <= 1. This applies even if a push happens in the same cycle.
- Push and pop in the same cycle:
  - level unchanged; frame_cnt changes by (push_eof - pop_eof).
  - When full, the pop frees the slot, so the push is accepted (no ovf).
- data_out/eof_out hold their last value when rd_vld=0.
- empty, full and port_busy are combinational decodes of the level register. No combinational path from wr_en or rd_en.
- clr_err=1 clears ovf/udf. If a new error occurs in the same cycle, the set wins.
- Pointers are $clog2(DEPTH) bits. level is separate so that full and empty are unambiguous.
- Assertions:
  - level never exceeds DEPTH.
  - frame_cnt <= level.

Decomposition:
- Package port_pkg:
  - W_WIDTH default.
  - Entry typedef {logic eof; logic [W_WIDTH-1:0] data}.
  - SOF_BYTE = 8'hFF, shared with the input FSM.
- One sub-module: fifo_mem. Register array, one synchronous write port and one registered read port, no reset on storage.
- Stage logic, counters and flags stay in port_in_fifo.

Test Plan:
- Write a 4-byte frame: wr_en high 4 cycles with data A1 A2 A3 A4 -> level=4 two cycles after the last byte; frame_cnt=1; only A4 stored with eof=1.
- Pop all 4 entries -> data_out A1..A4 each one cycle after rd_en; eof_out=1 only on A4; frame_cnt returns to 0; empty=1.
- DEPTH=8, AF_MARGIN=2, stream 10 bytes with no reads:
  - port_busy=1 once level=6.
  - full at 8.
  - 9th and 10th bytes dropped; ovf=1; level stays 8.
  - clr_err clears ovf.
- Full FIFO, simultaneous push and pop every cycle for 5 cycles -> level stays 8, no ovf, pointers wrap correctly (read order preserved).
- rd_en on empty during a single-byte frame push (0x3C) -> udf=1, rd_vld=0; entry 0x3C stored with eof=1, frame_cnt=1.
- rst_n low mid-frame (stage_vld=1, level=3) -> all outputs at reset values immediately; the partial frame is discarded and not pushed after release.
